uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Control and serializer stage of the UART transmitter. It accepts a parallel byte with a valid strobe and latches it with the parity configuration. It then sequences start, data, optional parity and stop bits by driving the 2-bit select of the downstream 4:1 TX output mux, along with the serial data bit and parity bit that feed two of the mux inputs. The mux input mapping is fixed: I0 = constant 0 (start), I1 = constant 1 (stop/idle), I2 = `o_ser_data`, I3 = `o_par_bit`.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `CLKS_PER_BIT`, default 1: clock cycles each line bit is held; legal range is ≥1.
- `i_clk`  in  1  single clock; all flops rise-edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_P_DATA`  in  DATA_WIDTH  parallel payload.
- `i_data_valid`  in  1  payload valid strobe.
- `i_PAR_EN`  in  1  1 = insert parity bit.
- `i_PAR_TYP`  in  1  0 = even, 1 = odd.
- `o_mux_sel`  out  2  mux select: 00 start, 01 stop/idle, 10 data, 11 parity.
- `o_ser_data`  out  1  current payload bit, LSB first.
- `o_par_bit`  out  1  parity of the latched payload.
- `o_busy`  out  1  high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Output decode per state:
  - IDLE: sel = 01, busy = 0.
  - START: sel = 00.
  - DATA: sel = 10.
  - PARITY: sel = 11.
  - STOP: sel = 01.
  - busy = 1 in every state except IDLE.
- Accept: the block accepts a frame only in IDLE with `i_data_valid` = 1. On accept it latches `i_P_DATA` into a shift register, latches `i_PAR_EN` and `i_PAR_TYP`, and goes to START.
- Valid while busy: `i_data_valid` is ignored outside IDLE. There is no queueing and no error flag.
- Parity: `o_par_bit` = XOR-reduce(latched data) XOR latched PAR_TYP. It is computed at accept and held constant until the next accept.
- Bit timer: a counter counts 0..CLKS_PER_BIT-1 within each line bit and wraps to 0 on every bit end.
- Bit counter: counts data bits 0..DATA_WIDTH-1.
- Transitions (all taken at bit end):
  - START → DATA.
  - DATA → DATA with a right shift, until bit DATA_WIDTH-1 has been held.
  - DATA → PARITY if PAR_EN is latched, else → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- `o_ser_data` = shift_reg[0]. Input changes never alter a frame in progress, because all fields are latched.
- Reset (any time, including mid-frame) forces the following immediately and asynchronously; the line returns to idle-high via sel = 01:
  - state = IDLE;
  - o_mux_sel = 01, o_ser_data = 0, o_par_bit = 0, o_busy = 0;
  - shift register, counters and latched config all cleared.

## Timing
- Outputs are driven from flops only, with no combinational path from inputs to outputs.
- Accept at rising edge k. START is visible from edge k through k+CLKS_PER_BIT, with busy = 1 from edge k.
- Frame length is (1 + DATA_WIDTH + PAR_EN + 1) × CLKS_PER_BIT cycles. For DATA_WIDTH = 8 and CLKS_PER_BIT = 1, that is 11 cycles with parity and 10 without.
- busy falls on the edge that ends STOP, entering IDLE. The earliest next accept is at that same edge +1, so there is at least one idle-high cycle between frames.
- `i_data_valid` held high continuously produces back-to-back frames separated by exactly one IDLE cycle.

## Test plan
- Reset mid-DATA:
  - Stimulus: assert `i_rst_n` = 0 asynchronously during a DATA bit.
  - Required: within the same cycle, sel = 01, busy = 0, ser_data = 0, par_bit = 0.
  - After release, the next valid starts a fresh frame.
- Even-parity frame:
  - Stimulus: `i_P_DATA` = 8'hA5, PAR_EN = 1, PAR_TYP = 0, CLKS_PER_BIT = 1.
  - Required sel sequence: 00, 10×8, 11, 01.
  - Required mux-output line: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - Required busy: high for exactly 11 cycles.
- Odd parity, parity disabled:
  - Stimulus: 8'hA5 with PAR_TYP = 1 → par_bit = 1.
  - Stimulus: 8'h01 with PAR_EN = 0.
  - Required for 8'h01: line 0, 1,0,0,0,0,0,0,0, 1 (10 cycles); sel never 11.
- Valid while busy:
  - Stimulus: pulse valid with 8'hFF during the data phase of an 8'h00 frame.
  - Required: 8'h00 frame transmitted unchanged; 8'hFF never transmitted.
- Back-to-back valid:
  - Stimulus: hold valid = 1 with data 8'h3C.
  - Required: consecutive frames separated by exactly one IDLE cycle (sel = 01, busy = 0).
- Prescale:
  - Stimulus: CLKS_PER_BIT = 4, 8'h81, PAR_EN = 1.
  - Required: each line bit held 4 cycles; frame length 44 cycles; par_bit = 0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control: latches a byte and parity config, then sequences the
// 4:1 line mux through start, data (LSB first), optional parity and stop bits.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_P_DATA,
  input  logic                  i_data_valid,
  input  logic                  i_PAR_EN,
  input  logic                  i_PAR_TYP,
  output logic [1:0]            o_mux_sel,
  output logic                  o_ser_data,
  output logic                  o_par_bit,
  output logic                  o_busy
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TickLast = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  bit_end;

  assign bit_end = (tick_q == TickLast);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    // Timer idles at 0 so a new frame always starts on a fresh bit period.
    if (state_q == StIdle) begin
      tick_d = '0;
    end else begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (i_data_valid) begin
          shift_d  = i_P_DATA;
          par_en_d = i_PAR_EN;
          par_d    = (^i_P_DATA) ^ i_PAR_TYP;
          bit_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mux_sel = 2'b01;
    o_busy    = 1'b1;
    unique case (state_q)
      StIdle:   o_busy    = 1'b0;
      StStart:  o_mux_sel = 2'b00;
      StData:   o_mux_sel = 2'b10;
      StParity: o_mux_sel = 2'b11;
      StStop:   o_mux_sel = 2'b01;
      default:  o_busy    = 1'b0;
    endcase
  end

  assign o_ser_data = shift_q[0];
  assign o_par_bit  = par_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of frames with hand-computed line patterns,
// plus sequences for reset mid-frame, back-to-back valid and a 4x prescaled instance.
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] p_data, p_data4;
  logic       valid, valid4;
  logic       par_en, par_en4;
  logic       par_typ, par_typ4;
  logic [1:0] sel1, sel4;
  logic       ser1, ser4, parb1, parb4, busy1, busy4;

  int total = 0;
  int bad   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_P_DATA    (p_data),
    .i_data_valid(valid),
    .i_PAR_EN    (par_en),
    .i_PAR_TYP   (par_typ),
    .o_mux_sel   (sel1),
    .o_ser_data  (ser1),
    .o_par_bit   (parb1),
    .o_busy      (busy1)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_P_DATA    (p_data4),
    .i_data_valid(valid4),
    .i_PAR_EN    (par_en4),
    .i_PAR_TYP   (par_typ4),
    .o_mux_sel   (sel4),
    .o_ser_data  (ser4),
    .o_par_bit   (parb4),
    .o_busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    bit          pen;
    bit          ptyp;
    logic [10:0] line;   // bit i = line level during line bit i
    bit          par;
    int          inject; // cycle at which an 8'hFF valid pulse is attempted, -1 none
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Samples one whole frame, starting at the negedge inside the START bit.
  task automatic check_frame(input int cpb, input logic [10:0] line, input bit pen,
                             input bit par, input int inject, input string tag);
    int len;
    len = (10 + int'(pen)) * cpb;
    for (int c = 0; c < len; c++) begin
      int         b;
      logic [1:0] s, es;
      logic       sr, pb, bz, ln;
      @(negedge clk);
      b = c / cpb;
      if (b == 0)                 es = 2'b00;
      else if (b <= 8)            es = 2'b10;
      else if (b == 9 && pen)     es = 2'b11;
      else                        es = 2'b01;
      if (cpb == 1) begin s = sel1; sr = ser1; pb = parb1; bz = busy1; end
      else          begin s = sel4; sr = ser4; pb = parb4; bz = busy4; end
      case (s)
        2'b00:   ln = 1'b0;
        2'b01:   ln = 1'b1;
        2'b10:   ln = sr;
        default: ln = pb;
      endcase
      chk($sformatf("%s sel c%0d", tag, c), 32'(s), 32'(es));
      chk($sformatf("%s line c%0d", tag, c), 32'(ln), 32'(line[b]));
      chk($sformatf("%s busy c%0d", tag, c), 32'(bz), 32'd1);
      if (c == 0) chk($sformatf("%s par_bit", tag), 32'(pb), 32'(par));
      if (inject == c) begin
        p_data = 8'hFF;
        valid  = 1'b1;
      end else if (inject >= 0 && c == inject + 1) begin
        valid = 1'b0;
      end
    end
  endtask

  task automatic check_idle(input int cpb, input string tag);
    @(negedge clk);
    if (cpb == 1) begin
      chk({tag, " idle sel"}, 32'(sel1), 32'd1);
      chk({tag, " idle busy"}, 32'(busy1), 32'd0);
    end else begin
      chk({tag, " idle sel"}, 32'(sel4), 32'd1);
      chk({tag, " idle busy"}, 32'(busy4), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, pen: 1'b1, ptyp: 1'b0, line: 11'b101_0100_1010, par: 1'b0, inject: -1};
    vecs[1] = '{data: 8'hA5, pen: 1'b1, ptyp: 1'b1, line: 11'b111_0100_1010, par: 1'b1, inject: -1};
    vecs[2] = '{data: 8'h01, pen: 1'b0, ptyp: 1'b0, line: 11'b010_0000_0010, par: 1'b1, inject: -1};
    vecs[3] = '{data: 8'h00, pen: 1'b1, ptyp: 1'b0, line: 11'b100_0000_0000, par: 1'b0, inject: 3};
    vecs[4] = '{data: 8'h3C, pen: 1'b1, ptyp: 1'b1, line: 11'b110_0111_1000, par: 1'b1, inject: -1};

    rst_n = 1'b0;
    p_data = '0; valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    p_data4 = '0; valid4 = 1'b0; par_en4 = 1'b0; par_typ4 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst sel", 32'(sel1), 32'd1);
    chk("rst busy", 32'(busy1), 32'd0);
    chk("rst ser", 32'(ser1), 32'd0);
    chk("rst par", 32'(parb1), 32'd0);
    chk("rst sel4", 32'(sel4), 32'd1);
    rst_n = 1'b1;
    check_idle(1, "post-rst");

    foreach (vecs[i]) begin
      @(negedge clk);
      p_data = vecs[i].data; par_en = vecs[i].pen; par_typ = vecs[i].ptyp; valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      check_frame(1, vecs[i].line, vecs[i].pen, vecs[i].par, vecs[i].inject,
                  $sformatf("vec%0d", i));
      check_idle(1, $sformatf("vec%0d", i));
    end

    // Back-to-back: valid held high across two frames.
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b1; valid = 1'b1;
    @(posedge clk);
    check_frame(1, vecs[4].line, 1'b1, 1'b1, -1, "b2b0");
    check_idle(1, "b2b gap");
    check_frame(1, vecs[4].line, 1'b1, 1'b1, -1, "b2b1");
    valid = 1'b0;
    check_idle(1, "b2b end");

    // Asynchronous reset in the middle of DATA bit 2 of an odd-parity 8'hA5 frame.
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b1; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst ser", 32'(ser1), 32'd1);
    chk("pre-rst par", 32'(parb1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst sel", 32'(sel1), 32'd1);
    chk("midrst busy", 32'(busy1), 32'd0);
    chk("midrst ser", 32'(ser1), 32'd0);
    chk("midrst par", 32'(parb1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    check_frame(1, vecs[0].line, 1'b1, 1'b0, -1, "after-rst");
    check_idle(1, "after-rst");

    // Prescaled instance: each bit held 4 cycles, 44-cycle frame.
    @(negedge clk);
    p_data4 = 8'h81; par_en4 = 1'b1; par_typ4 = 1'b0; valid4 = 1'b1;
    @(posedge clk);
    #1 valid4 = 1'b0;
    check_frame(4, 11'b101_0000_0010, 1'b1, 1'b0, -1, "cpb4");
    check_idle(4, "cpb4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
